// File: rtl/aes128_encrypt_sequencer.sv
// Iterative AES-128 encryptor: five two-round stage calls per block, valid/ready on both sides.
// Byte 0 of every 128-bit word (block or round key) sits in bits [127:120].
module aes128_encrypt_sequencer #(
    parameter int unsigned BLOCK_SIZE = 128,
    parameter int unsigned KS_WIDTH   = 1408,
    parameter int unsigned NUM_STAGES = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BLOCK_SIZE-1:0] in_block,
    input  logic [KS_WIDTH-1:0]   in_key_schedule,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BLOCK_SIZE-1:0] out_block,
    output logic                  busy,
    input  logic                  flush,
    output logic [15:0]           blk_count
);

    localparam logic [3:0] LastRound = 4'(2 * NUM_STAGES - 1);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   sb [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        // SubBytes fused with ShiftRows: row r of column c comes from column (c + r) mod 4.
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                sb[4*c+row] = sbox(s[127 - 8 * (4 * ((c + row) % 4) + row) -: 8]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sb[4*c];
            a1 = sb[4*c+1];
            a2 = sb[4*c+2];
            a3 = sb[4*c+3];
            if (last) begin
                r[127 - 32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                r[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                       a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                       a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                       xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
            end
        end
        return r ^ rk;
    endfunction

    // Applies AES rounds `round` and `round`+1; round 1 also folds in the initial AddRoundKey.
    function automatic logic [127:0] fn_aes_encrypt_stage(input logic [127:0]  st,
                                                          input logic [1407:0] ks,
                                                          input logic [3:0]    round);
        logic [127:0] s;
        s = (round == 4'd1) ? (st ^ ks[127:0]) : st;
        s = aes_round(s, ks[128 * int'(round) +: 128], 1'b0);
        s = aes_round(s, ks[128 * (int'(round) + 1) +: 128], round == LastRound);
        return s;
    endfunction

    fsm_e                  fsm_q, fsm_d;
    logic [BLOCK_SIZE-1:0] state_q, state_d;
    logic [KS_WIDTH-1:0]   key_q, key_d;
    logic [3:0]            round_q, round_d;
    logic [BLOCK_SIZE-1:0] out_block_q, out_block_d;
    logic [15:0]           blk_count_q, blk_count_d;

    logic [BLOCK_SIZE-1:0] stage_state, stage_res;
    logic [KS_WIDTH-1:0]   stage_key;
    logic [3:0]            stage_round;

    // In DONE the stage is idle, so it runs round 1 of a back-to-back block at its accept edge;
    // that keeps one block per five cycles.
    always_comb begin
        stage_state = state_q;
        stage_key   = key_q;
        stage_round = round_q;
        if (fsm_q == StDone) begin
            stage_state = in_block;
            stage_key   = in_key_schedule;
            stage_round = 4'd1;
        end
        stage_res = fn_aes_encrypt_stage(stage_state, stage_key, stage_round);
    end

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        key_d       = key_q;
        round_d     = round_q;
        out_block_d = out_block_q;
        blk_count_d = blk_count_q;
        in_ready    = 1'b0;
        unique case (fsm_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = in_block;
                    key_d   = in_key_schedule;
                    round_d = 4'd1;
                    fsm_d   = StRun;
                end
            end
            StRun: begin
                case (round_q)
                    4'd1, 4'd3, 4'd5, 4'd7: begin
                        state_d = stage_res;
                        round_d = round_q + 4'd2;
                    end
                    LastRound: begin
                        state_d     = stage_res;
                        out_block_d = stage_res;
                        round_d     = 4'd0;
                        fsm_d       = StDone;
                    end
                    default: begin
                        round_d = 4'd0;
                        fsm_d   = StIdle;
                    end
                endcase
            end
            StDone: begin
                in_ready = out_ready;
                if (out_ready) begin
                    blk_count_d = blk_count_q + 16'd1;
                    if (in_valid) begin
                        state_d = stage_res;
                        key_d   = in_key_schedule;
                        round_d = 4'd3;
                        fsm_d   = StRun;
                    end else begin
                        fsm_d = StIdle;
                    end
                end
            end
            default: fsm_d = StIdle;
        endcase
        if (flush) begin
            in_ready    = 1'b0;
            fsm_d       = StIdle;
            round_d     = 4'd0;
            state_d     = state_q;
            key_d       = key_q;
            out_block_d = out_block_q;
            blk_count_d = blk_count_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= StIdle;
            state_q     <= '0;
            key_q       <= '0;
            round_q     <= '0;
            out_block_q <= '0;
            blk_count_q <= '0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            key_q       <= key_d;
            round_q     <= round_d;
            out_block_q <= out_block_d;
            blk_count_q <= blk_count_d;
        end
    end

    assign out_valid = (fsm_q == StDone);
    assign busy      = (fsm_q != StIdle);
    assign out_block = out_block_q;
    assign blk_count = blk_count_q;

endmodule

// File: tb/tb_aes128_encrypt_sequencer.sv
// Directed bench for aes128_encrypt_sequencer using FIPS-197 vectors; keys are expanded here.
module tb_aes128_encrypt_sequencer;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [127:0]  in_block = '0;
    logic [1407:0] in_key_schedule = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [127:0]  out_block;
    logic          busy;
    logic          flush = 1'b0;
    logic [15:0]   blk_count;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] exp_count = '0;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic [2047:0] sbox_flat = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [1407:0] ks_b, ks_c, ks_z;

    aes128_encrypt_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_block        (in_block),
        .in_key_schedule (in_key_schedule),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_block       (out_block),
        .busy            (busy),
        .flush           (flush),
        .blk_count       (blk_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] sb(input logic [7:0] b);
        return sbox_flat[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [1407:0] expand_key(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1407:0] ks;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ks[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ks;
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    // Presents one block and returns at the negedge right after its accept edge.
    task automatic send(input logic [127:0] pt, input logic [1407:0] ks);
        in_block        = pt;
        in_key_schedule = ks;
        in_valid        = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) tick();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (out_block !== 128'h0) begin n_fail++; $display("FAIL rst_out_block: got %h want 0", out_block); end
        n_checks++; if (blk_count !== 16'h0) begin n_fail++; $display("FAIL rst_blk_count: got %h want 0", blk_count); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fips_b;
        int n;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b_idle_ready: got %b want 1", in_ready); end
        send(PT_B, ks_b);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b_busy: got %b want 1", busy); end
        wait_valid(n);
        n_checks++; if (n != 5) begin n_fail++; $display("FAIL b_latency: got %0d want 5", n); end
        n_checks++; if (out_block !== CT_B) begin n_fail++; $display("FAIL b_ct: got %h want %h", out_block, CT_B); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_count++;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b_valid_drop: got %b want 0", out_valid); end
        n_checks++; if (blk_count !== exp_count) begin n_fail++; $display("FAIL b_count: got %0d want %0d", blk_count, exp_count); end
    endtask

    task automatic test_backpressure;
        int n;
        send(PT_C, ks_c);
        wait_valid(n);
        n_checks++; if (n != 5) begin n_fail++; $display("FAIL bp_latency: got %0d want 5", n); end
        for (int i = 0; i < 7; i++) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, out_valid); end
            n_checks++; if (out_block !== CT_C) begin n_fail++; $display("FAIL bp_hold_ct[%0d]: got %h want %h", i, out_block, CT_C); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_follows: got %b want 1", in_ready); end
        tick();
        out_ready = 1'b0;
        exp_count++;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_single_hs: got %b want 0", out_valid); end
        n_checks++; if (blk_count !== exp_count) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", blk_count, exp_count); end
    endtask

    task automatic test_back_to_back;
        logic [127:0]  pts [4];
        logic [1407:0] kss [4];
        logic [127:0]  cts [4];
        int   t, idx, k;
        logic acc;
        pts = '{PT_B, PT_C, 128'h0, PT_B};
        kss = '{ks_b, ks_c, ks_z, ks_b};
        cts = '{CT_B, CT_C, CT_Z, CT_B};
        in_block        = pts[0];
        in_key_schedule = kss[0];
        in_valid        = 1'b1;
        out_ready       = 1'b1;
        idx = 0;
        k   = 0;
        t   = -1;
        while (t < 24) begin
            if (out_valid) begin
                if (k < 4) begin
                    n_checks++; if (t != 5 * (k + 1)) begin n_fail++; $display("FAIL b2b_cycle[%0d]: got %0d want %0d", k, t, 5 * (k + 1)); end
                    n_checks++; if (out_block !== cts[k]) begin n_fail++; $display("FAIL b2b_ct[%0d]: got %h want %h", k, out_block, cts[k]); end
                end else begin
                    n_checks++; n_fail++; $display("FAIL b2b_extra: got output %0d want none", k);
                end
                k++;
                exp_count++;
            end
            acc = in_valid && in_ready;
            tick();
            t++;
            if (acc) begin
                idx++;
                if (idx < 4) begin
                    in_block        = pts[idx];
                    in_key_schedule = kss[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        n_checks++; if (k != 4) begin n_fail++; $display("FAIL b2b_outputs: got %0d want 4", k); end
        n_checks++; if (blk_count !== exp_count) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", blk_count, exp_count); end
    endtask

    task automatic test_key_isolation;
        int n;
        send(PT_B, ks_b);
        tick();
        in_key_schedule = ks_c;
        wait_valid(n);
        n_checks++; if (n != 4) begin n_fail++; $display("FAIL key_iso_latency: got %0d want 4", n); end
        n_checks++; if (out_block !== CT_B) begin n_fail++; $display("FAIL key_iso_ct: got %h want %h", out_block, CT_B); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_count++;
    endtask

    task automatic test_flush;
        int n, seen;
        send(PT_B, ks_b);
        repeat (2) tick();
        flush           = 1'b1;
        in_valid        = 1'b1;
        in_block        = PT_C;
        in_key_schedule = ks_c;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready_low: got %b want 0", in_ready); end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready_after: got %b want 1", in_ready); end
        seen = 0;
        out_ready = 1'b1;
        repeat (8) begin
            if (out_valid) seen++;
            tick();
        end
        out_ready = 1'b0;
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL flush_no_output: got %0d want 0", seen); end
        n_checks++; if (blk_count !== exp_count) begin n_fail++; $display("FAIL flush_count: got %0d want %0d", blk_count, exp_count); end
        send(PT_C, ks_c);
        wait_valid(n);
        n_checks++; if (n != 5) begin n_fail++; $display("FAIL flush_next_latency: got %0d want 5", n); end
        n_checks++; if (out_block !== CT_C) begin n_fail++; $display("FAIL flush_next_ct: got %h want %h", out_block, CT_C); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_count++;
    endtask

    task automatic test_async_reset;
        send(PT_B, ks_b);
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ar_busy: got %b want 0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_ready: got %b want 1", in_ready); end
        n_checks++; if (out_block !== 128'h0) begin n_fail++; $display("FAIL ar_block: got %h want 0", out_block); end
        n_checks++; if (blk_count !== 16'h0) begin n_fail++; $display("FAIL ar_count: got %h want 0", blk_count); end
        exp_count = '0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_wrap;
        int n;
        force dut.blk_count_q = 16'hffff;
        #1;
        release dut.blk_count_q;
        tick();
        n_checks++; if (blk_count !== 16'hffff) begin n_fail++; $display("FAIL wrap_hold: got %h want ffff", blk_count); end
        send(128'h0, ks_z);
        wait_valid(n);
        n_checks++; if (out_block !== CT_Z) begin n_fail++; $display("FAIL wrap_ct: got %h want %h", out_block, CT_Z); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++; if (blk_count !== 16'h0) begin n_fail++; $display("FAIL wrap_count: got %h want 0", blk_count); end
    endtask

    initial begin
        ks_b = expand_key(KEY_B);
        ks_c = expand_key(KEY_C);
        ks_z = expand_key(128'h0);
        tick();
        test_reset();
        test_fips_b();
        test_backpressure();
        test_back_to_back();
        test_key_isolation();
        test_flush();
        test_async_reset();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
